// File: rtl/sysmon_pkg.sv
// Shared types and constants for the SYSMON DRP arbiter: bus widths,
// channel address map and the DRP transaction FSM states.
package sysmon_pkg;

    localparam int DRP_ADDR_W = 8;
    localparam int DRP_DATA_W = 16;
    localparam int CHAN_W     = 6;

    localparam logic [CHAN_W-1:0] CH_TEMP   = 6'd0;
    localparam logic [CHAN_W-1:0] CH_VAUX0  = 6'd16;
    localparam logic [CHAN_W-1:0] CH_VAUX15 = 6'd31;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } drp_state_t;

    // Status registers for channel N live at DRP address N.
    function automatic logic [DRP_ADDR_W-1:0] chan_to_addr(input logic [CHAN_W-1:0] ch);
        return {2'b00, ch};
    endfunction

endpackage

// File: rtl/sysmon_drp_arb.sv
// Arbitrates the SYSMON DRP port between end-of-conversion auto-readback and a host.
// Define SYSMON_DRP_TIMEOUT_EN to abort DRP waits after TIMEOUT_CYCLES cycles.
module sysmon_drp_arb
    import sysmon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  eoc,
    input  logic [CHAN_W-1:0]     channel,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [DRP_ADDR_W-1:0] host_addr,
    input  logic [DRP_DATA_W-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DRP_DATA_W-1:0] host_rdata,
    output logic                  host_err,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [DRP_ADDR_W-1:0] drp_daddr,
    output logic [DRP_DATA_W-1:0] drp_di,
    input  logic [DRP_DATA_W-1:0] drp_do,
    input  logic                  drp_drdy,
    output logic                  auto_vld,
    output logic [CHAN_W-1:0]     auto_ch,
    output logic [DRP_DATA_W-1:0] auto_data,
    output logic                  auto_drop
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..1023");
    end

    drp_state_t        state, state_next;
    logic              auto_pend;
    logic [CHAN_W-1:0] pend_ch;
    logic              host_lost;
    logic              grant_auto;
    logic              grant_we;
    logic [CHAN_W-1:0] grant_ch;

    logic              auto_avail;
    logic [CHAN_W-1:0] auto_sel_ch;
    logic              do_grant;
    logic              grant_auto_now;
    logic              finish;
    logic              timeout_hit;
    logic              eoc_overwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fresh eoc with nothing pending is granted directly, so an idle
    // arbiter starts the DRP read on the edge after eoc is sampled.
    always_comb begin
        state_next     = state;
        do_grant       = 1'b0;
        finish         = 1'b0;
        auto_avail     = auto_pend | eoc;
        auto_sel_ch    = auto_pend ? pend_ch : channel;
        case (state)
            IDLE: begin
                if (auto_avail || host_req) begin
                    do_grant   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (drp_drdy || timeout_hit) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        grant_auto_now = do_grant & auto_avail & (~host_req | ~host_lost);
        eoc_overwrite  = eoc & auto_pend & ~grant_auto_now;
    end

`ifdef SYSMON_DRP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !finish) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_err <= 1'b0;
        end else begin
            host_err <= finish & ~grant_auto & ~drp_drdy;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign host_err    = 1'b0;
`endif

    // Pending auto-read latch plus the fairness flag, which only changes
    // when both requesters compete for the same grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_pend  <= 1'b0;
            pend_ch    <= '0;
            host_lost  <= 1'b0;
            grant_auto <= 1'b0;
            grant_we   <= 1'b0;
            grant_ch   <= '0;
        end else begin
            if (eoc) begin
                auto_pend <= ~(grant_auto_now & ~auto_pend);
                pend_ch   <= channel;
            end else if (grant_auto_now) begin
                auto_pend <= 1'b0;
            end
            if (do_grant) begin
                grant_auto <= grant_auto_now;
                grant_we   <= host_we & ~grant_auto_now;
                grant_ch   <= auto_sel_ch;
                if (auto_avail && host_req) begin
                    host_lost <= grant_auto_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            drp_daddr  <= '0;
            drp_di     <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            auto_vld   <= 1'b0;
            auto_ch    <= '0;
            auto_data  <= '0;
            auto_drop  <= 1'b0;
        end else begin
            drp_den    <= do_grant;
            drp_dwe    <= do_grant & ~grant_auto_now & host_we;
            drp_daddr  <= !do_grant ? '0 :
                          grant_auto_now ? chan_to_addr(auto_sel_ch) : host_addr;
            drp_di     <= (do_grant && !grant_auto_now && host_we) ? host_wdata : '0;
            host_ack   <= finish & ~grant_auto;
            host_rdata <= (finish && !grant_auto && drp_drdy && !grant_we) ? drp_do : '0;
            auto_vld   <= finish & grant_auto & drp_drdy;
            auto_ch    <= (finish && grant_auto && drp_drdy) ? grant_ch : '0;
            auto_data  <= (finish && grant_auto && drp_drdy) ? drp_do : '0;
            auto_drop  <= eoc_overwrite | (finish & grant_auto & ~drp_drdy);
        end
    end

endmodule

// File: tb/tb_sysmon_drp_arb.sv
// Directed bench for sysmon_drp_arb: auto readback, host access, fairness,
// overwrite drop, optional timeout and mid-transaction reset.
module tb_sysmon_drp_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc = 1'b0;
    logic [5:0]  channel = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_err;
    logic        drp_den;
    logic        drp_dwe;
    logic [7:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        auto_vld;
    logic [5:0]  auto_ch;
    logic [15:0] auto_data;
    logic        auto_drop;

    int errors = 0;
    int checks = 0;
    int den_cnt = 0;
    int drop_cnt = 0;
    int vld_cnt = 0;
    int ack_cnt = 0;
    int saw_addr10 = 0;

    sysmon_drp_arb #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eoc        (eoc),
        .channel    (channel),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_daddr  (drp_daddr),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .auto_vld   (auto_vld),
        .auto_ch    (auto_ch),
        .auto_data  (auto_data),
        .auto_drop  (auto_drop)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (drp_den) begin
            den_cnt++;
            if (drp_daddr == 8'h10) saw_addr10++;
        end
        if (auto_drop) drop_cnt++;
        if (auto_vld)  vld_cnt++;
        if (host_ack)  ack_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [7:0] addr,
                                 input logic [15:0] wdata, input logic eoc_in, input logic [5:0] ch);
        host_req   = req;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        eoc        = eoc_in;
        channel    = ch;
    endtask

    task automatic waitDen(input string tag, input int max_cycles);
        int n = 0;
        while (!drp_den && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, drp_den}, 32'd1);
    endtask

    task automatic drpRespond(input int delay, input logic [15:0] data);
        repeat (delay) tick();
        drp_drdy = 1'b1;
        drp_do   = data;
        tick();
        drp_drdy = 1'b0;
        drp_do   = '0;
    endtask

    task automatic releaseHost();
        host_req = 1'b0;
        tick();
    endtask

    int b_den, b_drop, b_vld, b_ack, b_a10;

    initial begin
        // Outputs must stay quiet in reset even with requests asserted.
        applyStimulus(1'b1, 1'b0, 8'h40, 16'h0, 1'b1, 6'd5);
        #12;
        checkOutput("reset drp", {6'd0, drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
        checkOutput("reset host", {14'd0, host_ack, host_err, host_rdata}, 32'd0);
        checkOutput("reset auto", {8'd0, auto_vld, auto_drop, auto_ch, auto_data}, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 6'd0);
        #10 rst_n = 1'b1;
        tick();

        // Auto readback of channel 17.
        b_den = den_cnt;
        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 6'd17);
        tick();
        eoc = 1'b0;
        waitDen("auto den latency", 1);
        checkOutput("auto daddr", {24'd0, drp_daddr}, 32'h11);
        checkOutput("auto dwe", {31'd0, drp_dwe}, 32'd0);
        drpRespond(3, 16'h1234);
        checkOutput("auto vld", {31'd0, auto_vld}, 32'd1);
        checkOutput("auto ch", {26'd0, auto_ch}, 32'd17);
        checkOutput("auto data", {16'd0, auto_data}, 32'h1234);
        tick();
        checkOutput("auto vld pulse", {31'd0, auto_vld}, 32'd0);
        checkOutput("auto den count", den_cnt - b_den, 32'd1);

        // Host read and host write.
        applyStimulus(1'b1, 1'b0, 8'h40, 16'h0, 1'b0, 6'd0);
        tick();
        waitDen("host rd den", 1);
        checkOutput("host rd daddr", {24'd0, drp_daddr}, 32'h40);
        checkOutput("host rd dwe", {31'd0, drp_dwe}, 32'd0);
        drpRespond(2, 16'hBEEF);
        checkOutput("host rd ack", {31'd0, host_ack}, 32'd1);
        checkOutput("host rd data", {16'd0, host_rdata}, 32'hBEEF);
        checkOutput("host rd err", {31'd0, host_err}, 32'd0);
        releaseHost();
        checkOutput("host ack pulse", {31'd0, host_ack}, 32'd0);

        applyStimulus(1'b1, 1'b1, 8'h41, 16'h5A5A, 1'b0, 6'd0);
        tick();
        waitDen("host wr den", 1);
        checkOutput("host wr dwe", {31'd0, drp_dwe}, 32'd1);
        checkOutput("host wr di", {16'd0, drp_di}, 32'h5A5A);
        drpRespond(1, 16'hFFFF);
        checkOutput("host wr ack", {31'd0, host_ack}, 32'd1);
        checkOutput("host wr rdata", {16'd0, host_rdata}, 32'd0);
        releaseHost();

        // Two eocs while the host holds the DRP: ch16 is overwritten by ch18.
        b_den  = den_cnt;
        b_drop = drop_cnt;
        b_a10  = saw_addr10;
        applyStimulus(1'b1, 1'b0, 8'h42, 16'h0, 1'b0, 6'd0);
        tick();
        waitDen("drop host den", 1);
        applyStimulus(1'b1, 1'b0, 8'h42, 16'h0, 1'b1, 6'd16);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h42, 16'h0, 1'b0, 6'd16);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h42, 16'h0, 1'b1, 6'd18);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h42, 16'h0, 1'b0, 6'd18);
        checkOutput("drop pulse", {31'd0, auto_drop}, 32'd1);
        drpRespond(1, 16'h0042);
        checkOutput("drop host ack", {31'd0, host_ack}, 32'd1);
        checkOutput("drop host data", {16'd0, host_rdata}, 32'h0042);
        releaseHost();
        waitDen("drop auto den", 3);
        checkOutput("drop auto daddr", {24'd0, drp_daddr}, 32'h12);
        drpRespond(2, 16'h0777);
        checkOutput("drop auto vld", {31'd0, auto_vld}, 32'd1);
        checkOutput("drop auto ch", {26'd0, auto_ch}, 32'd18);
        tick();
        checkOutput("drop count", drop_cnt - b_drop, 32'd1);
        checkOutput("drop den count", den_cnt - b_den, 32'd2);
        checkOutput("drop no ch16 read", saw_addr10 - b_a10, 32'd0);

        // Contested twice: auto wins first, host wins the next contest.
        applyStimulus(1'b1, 1'b0, 8'h44, 16'h0, 1'b1, 6'd20);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h44, 16'h0, 1'b0, 6'd20);
        waitDen("fair1 den", 1);
        checkOutput("fair1 winner auto", {24'd0, drp_daddr}, 32'h14);
        drpRespond(1, 16'hAAAA);
        checkOutput("fair1 auto vld", {31'd0, auto_vld}, 32'd1);
        checkOutput("fair1 auto data", {16'd0, auto_data}, 32'hAAAA);
        waitDen("fair1 host den", 4);
        checkOutput("fair1 host daddr", {24'd0, drp_daddr}, 32'h44);
        drpRespond(1, 16'h4444);
        checkOutput("fair1 host ack", {31'd0, host_ack}, 32'd1);
        releaseHost();

        applyStimulus(1'b1, 1'b0, 8'h45, 16'h0, 1'b1, 6'd21);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h45, 16'h0, 1'b0, 6'd21);
        waitDen("fair2 den", 1);
        checkOutput("fair2 winner host", {24'd0, drp_daddr}, 32'h45);
        drpRespond(1, 16'h4545);
        checkOutput("fair2 host ack", {31'd0, host_ack}, 32'd1);
        checkOutput("fair2 host data", {16'd0, host_rdata}, 32'h4545);
        releaseHost();
        waitDen("fair2 auto den", 3);
        checkOutput("fair2 auto daddr", {24'd0, drp_daddr}, 32'h15);
        drpRespond(1, 16'h2121);
        checkOutput("fair2 auto vld", {31'd0, auto_vld}, 32'd1);
        checkOutput("fair2 auto ch", {26'd0, auto_ch}, 32'd21);
        checkOutput("fair2 auto data", {16'd0, auto_data}, 32'h2121);
        tick();

`ifdef SYSMON_DRP_TIMEOUT_EN
        // No drdy: host completes with an error 8 cycles after WAIT entry.
        applyStimulus(1'b1, 1'b0, 8'h47, 16'h0, 1'b0, 6'd0);
        tick();
        waitDen("tmo host den", 1);
        repeat (7) tick();
        checkOutput("tmo host early ack", {31'd0, host_ack}, 32'd0);
        tick();
        checkOutput("tmo host ack", {31'd0, host_ack}, 32'd1);
        checkOutput("tmo host err", {31'd0, host_err}, 32'd1);
        checkOutput("tmo host rdata", {16'd0, host_rdata}, 32'd0);
        releaseHost();

        applyStimulus(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 6'd19);
        tick();
        eoc = 1'b0;
        waitDen("tmo auto den", 1);
        repeat (8) tick();
        checkOutput("tmo auto drop", {31'd0, auto_drop}, 32'd1);
        checkOutput("tmo auto vld", {31'd0, auto_vld}, 32'd0);
        tick();
`else
        // Without the timeout a slow drdy still completes normally.
        applyStimulus(1'b1, 1'b0, 8'h46, 16'h0, 1'b0, 6'd0);
        tick();
        waitDen("slow host den", 1);
        drpRespond(12, 16'h0C0C);
        checkOutput("slow host ack", {31'd0, host_ack}, 32'd1);
        checkOutput("slow host err", {31'd0, host_err}, 32'd0);
        checkOutput("slow host data", {16'd0, host_rdata}, 32'h0C0C);
        releaseHost();
`endif

        // Reset in the middle of a host transaction.
        applyStimulus(1'b1, 1'b0, 8'h48, 16'h0, 1'b0, 6'd0);
        tick();
        waitDen("rst den", 1);
        checkOutput("rst daddr before", {24'd0, drp_daddr}, 32'h48);
        #2;
        rst_n    = 1'b0;
        host_req = 1'b0;
        #1;
        checkOutput("rst mid drp", {6'd0, drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
        checkOutput("rst mid host", {14'd0, host_ack, host_err, host_rdata}, 32'd0);
        checkOutput("rst mid auto", {8'd0, auto_vld, auto_drop, auto_ch, auto_data}, 32'd0);
        b_den  = den_cnt;
        b_drop = drop_cnt;
        b_vld  = vld_cnt;
        b_ack  = ack_cnt;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'hDEAD;
        tick();
        drp_drdy = 1'b0;
        drp_do   = '0;
        repeat (6) tick();
        checkOutput("rst no ack", ack_cnt - b_ack, 32'd0);
        checkOutput("rst no vld", vld_cnt - b_vld, 32'd0);
        checkOutput("rst no drop", drop_cnt - b_drop, 32'd0);
        checkOutput("rst no den", den_cnt - b_den, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
